// File: rtl/feature_stream_packer_if.sv
// feature_stream_packer_if: output word stream of feature_stream_packer.
// Valid/ready handshake with a per-entry last marker.
interface feature_stream_packer_if #(
    parameter int BUS_W = 32
);
    logic [BUS_W-1:0] o_data;
    logic             o_valid;
    logic             o_last;
    logic             i_ready;

    modport master (
        output o_data,
        output o_valid,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/feature_stream_packer.sv
// feature_stream_packer: buffers CHIP feature records and serialises them
// as BUS_W words. Optional frame header/trailer: define FEAT_FRAME_MARK_EN.
module feature_stream_packer #(
    parameter int COORD_W = 10,
    parameter int SCORE_W = 8,
    parameter int DESC_W  = 256,
    parameter int BUS_W   = 32,
    parameter int DEPTH   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [COORD_W-1:0]       i_coordinate_X,
    input  logic [COORD_W-1:0]       i_coordinate_Y,
    input  logic [SCORE_W-1:0]       i_score,
    input  logic [DESC_W-1:0]        i_descriptor,
    input  logic                     i_flag,
    input  logic                     i_start,
    input  logic                     i_end,
    feature_stream_packer_if.master  bus,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_cnt,
    output logic [15:0]              o_feat_cnt,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int REC_W = 2 * COORD_W + SCORE_W + DESC_W;
    localparam int WORDS = (REC_W + BUS_W - 1) / BUS_W;
    localparam int PAY_W = WORDS * BUS_W;
    localparam int ENT_W = PAY_W + 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int IW    = $clog2(WORDS) + 1;

`ifdef FEAT_FRAME_MARK_EN
    localparam bit MARK_EN = 1'b1;
`else
    localparam bit MARK_EN = 1'b0;
`endif

    localparam logic [1:0] TAG_REC = 2'd0;
    localparam logic [1:0] TAG_HDR = 2'd1;
    localparam logic [1:0] TAG_TRL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;

    logic [15:0]      feat_q;
    logic [15:0]      feat_d;
    logic [15:0]      feat_base;
    logic [7:0]       drop_q;
    logic [7:0]       drop_d;
    logic [7:0]       drop_base;
    logic [8:0]       drop_sum;
    logic             ovf_q;
    logic             ovf_d;

    logic             in_frame_q;
    logic [15:0]      frame_idx_q;

    state_t           state_q;
    logic [PAY_W-1:0] pay_q;
    logic [IW-1:0]    idx_q;
    logic             valid_q;
    logic             last_q;

    logic             xfer;
    logic             pop;
    logic [LW:0]      free;
    logic [1:0]       avail;
    logic [1:0]       n_push;
    logic [1:0]       n_drop;
    logic             want_hdr;
    logic             want_trl;
    logic             acc_hdr;
    logic             acc_rec;
    logic             acc_trl;
    logic [PAY_W-1:0] rec_pay;
    logic [PAY_W-1:0] hdr_pay;
    logic [PAY_W-1:0] trl_pay;
    logic [ENT_W-1:0] ent0;
    logic [ENT_W-1:0] ent1;
    logic [ENT_W-1:0] head;
    logic [1:0]       head_tag;

    // Handshake, pop on final word, and free-slot budget for this cycle
    always_comb begin
        xfer  = valid_q & bus.i_ready;
        pop   = xfer & last_q;
        free  = (LW+1)'(DEPTH) - (LW+1)'(level_q) + (LW+1)'(pop);
        avail = (free >= (LW+1)'(2)) ? 2'd2 : free[1:0];
    end

    // Slot allocation: markers first, record takes what remains
    always_comb begin
        want_hdr = MARK_EN & i_start;
        want_trl = MARK_EN & i_end & (in_frame_q | i_start);
        acc_hdr  = want_hdr & (avail != 2'd0);
        acc_trl  = want_trl & (avail > {1'b0, acc_hdr});
        acc_rec  = i_flag &
                   (avail > ({1'b0, acc_hdr} + {1'b0, acc_trl}));
        n_push   = {1'b0, acc_hdr} + {1'b0, acc_rec} + {1'b0, acc_trl};
        n_drop   = {1'b0, i_flag & ~acc_rec}
                 + {1'b0, want_hdr & ~acc_hdr}
                 + {1'b0, want_trl & ~acc_trl};
    end

    // Frame accounting; start clears before this cycle's events
    always_comb begin
        feat_base = i_start ? 16'd0 : feat_q;
        feat_d    = feat_base;
        if (acc_rec && feat_base != 16'hFFFF) begin
            feat_d = feat_base + 16'd1;
        end
        drop_base = i_start ? 8'd0 : drop_q;
        drop_sum  = 9'(drop_base) + 9'(n_drop);
        drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        ovf_d     = (i_start ? 1'b0 : ovf_q) | (n_drop != 2'd0);
        level_d   = level_q - LW'(pop) + LW'(n_push);
    end

    // Entry payloads and in-order packing of up to two pushes
    always_comb begin
        rec_pay = PAY_W'({i_descriptor, i_score,
                          i_coordinate_Y, i_coordinate_X});
        hdr_pay = PAY_W'({16'h5EAD, frame_idx_q});
        trl_pay = PAY_W'({16'hE0D0, feat_d});
        if (acc_hdr) begin
            ent0 = {TAG_HDR, hdr_pay};
        end else if (acc_rec) begin
            ent0 = {TAG_REC, rec_pay};
        end else begin
            ent0 = {TAG_TRL, trl_pay};
        end
        if (acc_hdr && acc_rec) begin
            ent1 = {TAG_REC, rec_pay};
        end else begin
            ent1 = {TAG_TRL, trl_pay};
        end
        head     = mem_q[rd_ptr_q];
        head_tag = head[ENT_W-1 -: 2];
    end

    // Entry storage; the head stays resident until its last word leaves
    always_ff @(posedge i_clk) begin
        if (n_push != 2'd0) begin
            mem_q[wr_ptr_q] <= ent0;
        end
        if (n_push == 2'd2) begin
            mem_q[wr_ptr_q + AW'(1)] <= ent1;
        end
    end

    // FIFO pointers, occupancy and per-frame counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            feat_q   <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(n_push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            level_q  <= level_d;
            feat_q   <= feat_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Frame tracking: open frame flag and wrapping header index
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_frame_q  <= 1'b0;
            frame_idx_q <= '0;
        end else begin
            if (i_start) begin
                frame_idx_q <= frame_idx_q + 16'd1;
            end
            if (i_end) begin
                in_frame_q <= 1'b0;
            end else if (i_start) begin
                in_frame_q <= 1'b1;
            end
        end
    end

    // Serializer: IDLE -> LOAD (capture head) -> SEND (word per transfer)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pay_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (level_q != '0) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    pay_q   <= head[PAY_W-1:0];
                    idx_q   <= '0;
                    valid_q <= 1'b1;
                    last_q  <= (head_tag != TAG_REC) || (WORDS == 1);
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state_q <= (level_d != '0) ? S_LOAD : S_IDLE;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            pay_q  <= pay_q >> BUS_W;
                            last_q <= (idx_q + 1'b1 == IW'(WORDS - 1));
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_data  = pay_q[BUS_W-1:0];
    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign o_level     = level_q;
    assign o_feat_cnt  = feat_q;
    assign o_drop_cnt  = drop_q;
    assign o_overflow  = ovf_q;

endmodule
